// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit for the EX stage
// Optional early completion of divide-by-zero/overflow: MULDIV_ZERO_SHORTCUT_EN
module ex_muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      in_rd_address,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_address,
   output logic            reg_write_enable
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t          state, next_state;
   logic [1:0]      op;
   logic [XLEN-1:0] op_a, op_b, quo, divisor, acc;
   logic [5:0]      count;
   logic            neg_q, neg_r;

   logic            signed_div, rs1_neg, rs2_neg;
   logic [XLEN-1:0] abs1, abs2;
   logic [2*XLEN-1:0] a_ext, b_ext, product;
   logic [XLEN-1:0] mul_res;
   logic [XLEN:0]   shifted, diff;
   logic            take;
   logic [XLEN-1:0] next_acc, next_quo, q_final, r_final, div_res;
   logic            accept, last_iter;

   assign signed_div = ~funct3[0];
   assign rs1_neg    = signed_div & rs1_data[XLEN-1];
   assign rs2_neg    = signed_div & rs2_data[XLEN-1];
   assign abs1       = rs1_neg ? -rs1_data : rs1_data;
   assign abs2       = rs2_neg ? -rs2_data : rs2_data;

   // op 1 (MULH) and 2 (MULHSU) treat rs1 as signed; only MULH treats rs2 as signed
   assign a_ext   = {{XLEN{(op != 2'd3) & op_a[XLEN-1]}}, op_a};
   assign b_ext   = {{XLEN{~op[1] & op_b[XLEN-1]}}, op_b};
   assign product = a_ext * b_ext;
   assign mul_res = (op == 2'd0) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

   // restoring step: acc stays below divisor, so the shifted value fits XLEN+1 bits
   assign shifted  = {acc, quo[XLEN-1]};
   assign diff     = shifted - {1'b0, divisor};
   assign take     = ~diff[XLEN];
   assign next_acc = take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
   assign next_quo = {quo[XLEN-2:0], take};
   assign q_final  = neg_q ? -next_quo : next_quo;
   assign r_final  = neg_r ? -next_acc : next_acc;
   assign div_res  = op[1] ? r_final : q_final;

   assign accept    = (state == IDLE) && start && !kill;
   assign last_iter = (count == 6'(XLEN - 1));

`ifdef MULDIV_ZERO_SHORTCUT_EN
   logic            special;
   logic [XLEN-1:0] special_res;
   assign special = (rs2_data == '0) |
                    (signed_div & (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_data == '1));
   assign special_res = (rs2_data == '0) ? (funct3[1] ? rs1_data : '1)
                                         : (funct3[1] ? '0 : rs1_data);
`endif

   always_comb begin
      next_state = state;
      stall      = 1'b0;
      case (state)
         IDLE: begin
            stall = start;
            if (start) begin
               next_state = funct3[2] ? DIV : MUL;
`ifdef MULDIV_ZERO_SHORTCUT_EN
               if (funct3[2] && special) next_state = DONE;
`endif
            end
         end
         MUL: begin
            stall      = 1'b1;
            next_state = DONE;
         end
         DIV: begin
            stall = 1'b1;
            if (last_iter) next_state = DONE;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (kill) next_state = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         op         <= '0;
         op_a       <= '0;
         op_b       <= '0;
         quo        <= '0;
         divisor    <= '0;
         acc        <= '0;
         count      <= '0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         result     <= '0;
         rd_address <= '0;
      end else begin
         state <= next_state;
         if (accept) begin
            op         <= funct3[1:0];
            op_a       <= rs1_data;
            op_b       <= rs2_data;
            rd_address <= in_rd_address;
            acc        <= '0;
            quo        <= abs1;
            divisor    <= abs2;
            count      <= '0;
            // a zero divisor must yield all-ones even for a negative dividend
            neg_q      <= (rs1_neg ^ rs2_neg) & (rs2_data != '0);
            neg_r      <= rs1_neg;
`ifdef MULDIV_ZERO_SHORTCUT_EN
            if (funct3[2] && special) result <= special_res;
`endif
         end
         if (state == MUL && !kill) result <= mul_res;
         if (state == DIV && !kill) begin
            acc   <= next_acc;
            quo   <= next_quo;
            count <= count + 6'd1;
            if (last_iter) result <= div_res;
         end
      end
   end

   assign busy             = (state != IDLE);
   assign done             = (state == DONE) && !kill;
   assign reg_write_enable = done && (rd_address != 5'd0);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        kill = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] rs1_data = '0;
   logic [31:0] rs2_data = '0;
   logic [4:0]  in_rd_address = '0;
   logic        stall, busy, done, reg_write_enable;
   logic [31:0] result;
   logic [4:0]  rd_address;

   int checks = 0;
   int errors = 0;
   int lat;

`ifdef MULDIV_ZERO_SHORTCUT_EN
   localparam int SPECIAL_LAT = 1;
`else
   localparam int SPECIAL_LAT = 33;
`endif

   ex_muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .kill(kill), .funct3(funct3),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .in_rd_address(in_rd_address),
      .stall(stall), .busy(busy), .done(done), .result(result),
      .rd_address(rd_address), .reg_write_enable(reg_write_enable)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      @(negedge clk);
      funct3 = f; rs1_data = a; rs2_data = b; in_rd_address = rd; start = 1'b1;
      #1 check("stall_on_start", {31'd0, stall}, 32'd1);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 1;
      @(negedge clk);
      while (!done && n < 60) begin
         checks++;
         assert (!(start && busy && stall)) else begin
            errors++;
            $error("FAIL start_while_busy: observed 1 expected 0");
         end
         @(posedge clk);
         n++;
         @(negedge clk);
      end
   endtask

   task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd,
                      input logic [31:0] exp_res, input int exp_lat);
      issue(f, a, b, rd);
      wait_done(lat);
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_result"}, result, exp_res);
      check({tag, "_rd"}, {27'd0, rd_address}, {27'd0, rd});
      check({tag, "_rwe"}, {31'd0, reg_write_enable}, {31'd0, rd != 5'd0});
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_result", result, 32'd0);
      check("reset_rd", {27'd0, rd_address}, 32'd0);
      check("reset_rwe", {31'd0, reg_write_enable}, 32'd0);
      check("reset_stall", {31'd0, stall}, 32'd0);
      reset_n = 1'b1;

      // MUL 7 * -3 with cycle-by-cycle stall/done
      issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1);
      @(negedge clk);
      check("mul_stall_c1", {31'd0, stall}, 32'd1);
      check("mul_done_c1", {31'd0, done}, 32'd0);
      @(negedge clk);
      check("mul_done_c2", {31'd0, done}, 32'd1);
      check("mul_stall_c2", {31'd0, stall}, 32'd0);
      check("mul_result", result, 32'hFFFF_FFEB);
      check("mul_rwe", {31'd0, reg_write_enable}, 32'd1);
      @(negedge clk);
      check("mul_done_pulse", {31'd0, done}, 32'd0);

      run("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 2);
      run("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF, 2);
      run("mulh_neg", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, 2);
      run("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 2);

      run("div_neg", 3'd4, 32'hFFFF_FFEC, 32'd3, 5'd5, 32'hFFFF_FFFA, 33);
      run("rem_neg", 3'd6, 32'hFFFF_FFEC, 32'd3, 5'd6, 32'hFFFF_FFFE, 33);
      run("divu", 3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 33);
      run("remu_rd0", 3'd7, 32'd100, 32'd7, 5'd0, 32'd2, 33);

      run("divu_by0", 3'd5, 32'd100, 32'd0, 5'd8, 32'hFFFF_FFFF, SPECIAL_LAT);
      run("remu_by0", 3'd7, 32'd100, 32'd0, 5'd8, 32'd100, SPECIAL_LAT);
      run("div_neg_by0", 3'd4, 32'hFFFF_FFFB, 32'd0, 5'd9, 32'hFFFF_FFFF, SPECIAL_LAT);
      run("rem_neg_by0", 3'd6, 32'hFFFF_FFFB, 32'd0, 5'd9, 32'hFFFF_FFFB, SPECIAL_LAT);
      run("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, SPECIAL_LAT);
      run("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0000_0000, SPECIAL_LAT);

      // kill a DIV at T+10: previous result (0) must survive, no done
      issue(3'd4, 32'd1000, 32'd3, 5'd11);
      repeat (9) @(posedge clk);
      #1 check("kill_busy_before", {31'd0, busy}, 32'd1);
      kill = 1'b1;
      @(posedge clk);
      #1 kill = 1'b0;
      @(negedge clk);
      check("kill_busy", {31'd0, busy}, 32'd0);
      check("kill_done", {31'd0, done}, 32'd0);
      check("kill_stall", {31'd0, stall}, 32'd0);
      check("kill_result", result, 32'h0000_0000);
      run("mul_after_kill", 3'd0, 32'd6, 32'd7, 5'd12, 32'd42, 2);

      // reset mid-DIV
      issue(3'd5, 32'd1000, 32'd3, 5'd13);
      repeat (4) @(posedge clk);
      #1 reset_n = 1'b0;
      @(posedge clk);
      #1;
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_done", {31'd0, done}, 32'd0);
      check("rst_mid_result", result, 32'd0);
      check("rst_mid_rd", {27'd0, rd_address}, 32'd0);
      reset_n = 1'b1;

      // back-to-back: MUL presented during the DIV's DONE cycle must wait for IDLE
      issue(3'd5, 32'd100, 32'd7, 5'd14);
      wait_done(lat);
      check("b2b_div_latency", 32'(lat), 32'd33);
      check("b2b_div_result", result, 32'd14);
      funct3 = 3'd0; rs1_data = 32'd6; rs2_data = 32'd9; in_rd_address = 5'd15; start = 1'b1;
      #1 check("b2b_done_stall", {31'd0, stall}, 32'd0);
      @(posedge clk);
      #1;
      check("b2b_idle_busy", {31'd0, busy}, 32'd0);
      check("b2b_idle_stall", {31'd0, stall}, 32'd1);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(lat);
      check("b2b_mul_latency", 32'(lat), 32'd2);
      check("b2b_mul_result", result, 32'd54);
      check("b2b_mul_rd", {27'd0, rd_address}, 32'd15);
      @(negedge clk);
      check("b2b_final_idle", {31'd0, busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
